// File: rtl/spmv_row_reducer_if.sv
// Bus bundle for the SpMV row reducer: product stream in, adder port, row-sum stream out.
// master is the reducer's view, slave is the surrounding datapath's view.
interface spmv_row_reducer_if #(
    parameter int WIDTH = 16
);
    logic             prod_valid;
    logic             prod_ready;
    logic [WIDTH-1:0] prod_data;
    logic             prod_last;

    logic             add_clk_en;
    logic [WIDTH-1:0] add_dataa;
    logic [WIDTH-1:0] add_datab;
    logic [WIDTH-1:0] add_result;
    logic             add_overflow;
    logic             add_underflow;

    logic             row_valid;
    logic             row_ready;
    logic [WIDTH-1:0] row_sum;
    logic             row_overflow;
    logic             row_underflow;

    modport master (
        input  prod_valid, prod_data, prod_last,
        output prod_ready,
        output add_clk_en, add_dataa, add_datab,
        input  add_result, add_overflow, add_underflow,
        output row_valid, row_sum, row_overflow, row_underflow,
        input  row_ready
    );

    modport slave (
        output prod_valid, prod_data, prod_last,
        input  prod_ready,
        input  add_clk_en, add_dataa, add_datab,
        output add_result, add_overflow, add_underflow,
        input  row_valid, row_sum, row_overflow, row_underflow,
        output row_ready
    );
endinterface

// File: rtl/spmv_row_reducer.sv
// Schedules fp16 products and returning partial sums into a fixed-latency adder,
// folding each row down to a single sum with sticky overflow/underflow flags.
module spmv_row_reducer #(
    parameter int LATENCY = 8,   // adder depth, must be >= 2
    parameter int WIDTH   = 16
) (
    input logic                clk_i,
    input logic                rst_ni,
    spmv_row_reducer_if.master bus
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_e;

    state_e               state_q, state_d;
    logic                 en_q;
    logic [LATENCY-1:0]   tag_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 pv_q, pv_d;
    logic [WIDTH-1:0]     p_q, p_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 issue;
    logic                 acc;
    logic                 res;

    // en_q doubles as "out of reset": it holds off prod_ready while reset is asserted.
    assign bus.prod_ready    = (state_q == ACCUM) && en_q;
    assign bus.add_clk_en    = en_q;
    assign bus.add_dataa     = a_q;
    assign bus.add_datab     = b_q;
    assign bus.row_valid     = (state_q == OUT);
    assign bus.row_sum       = p_q;
    assign bus.row_overflow  = ovf_q;
    assign bus.row_underflow = unf_q;

    assign acc = bus.prod_valid && bus.prod_ready;
    assign res = tag_q[LATENCY-1];

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        pv_d    = pv_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        ovf_d   = ovf_q | (res & bus.add_overflow);
        unf_d   = unf_q | (res & bus.add_underflow);

        // Pairing: result+product first, then pending with whichever is alone, else park it.
        if (res && acc) begin
            issue = 1'b1;
            a_d   = bus.add_result;
            b_d   = bus.prod_data;
        end else if (pv_q && (res || acc)) begin
            issue = 1'b1;
            a_d   = p_q;
            b_d   = res ? bus.add_result : bus.prod_data;
            pv_d  = 1'b0;
        end else if (res || acc) begin
            pv_d  = 1'b1;
            p_d   = res ? bus.add_result : bus.prod_data;
        end

        cnt_d = cnt_q + CW'(issue) - CW'(res);

        unique case (state_q)
            ACCUM: if (acc && bus.prod_last) state_d = DRAIN;
            DRAIN: if (cnt_q == '0 && !res && pv_q) state_d = OUT;
            OUT: begin
                if (bus.row_ready) begin
                    state_d = ACCUM;
                    pv_d    = 1'b0;
                    p_d     = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            en_q    <= 1'b0;
            tag_q   <= '0;
            cnt_q   <= '0;
            pv_q    <= 1'b0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
            tag_q   <= {tag_q[LATENCY-2:0], issue};
            cnt_q   <= cnt_d;
            pv_q    <= pv_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
endmodule

// File: doc/spmv_row_reducer.md
Name: spmv_row_reducer

Overview:
- Sits directly upstream of the half-precision pipelined `adder` in the sparse matrix-vector datapath.
- Consumes the stream of fp16 products (one per non-zero) from the multiplier stage and schedules operand pairs into the adder.
- Folds returning partial sums back in, hiding adder latency, and emits one fp16 row sum plus sticky overflow/underflow flags per matrix row.

Parameters:
- LATENCY, 8, adder pipeline depth in cycles; result for an issue at cycle t is consumed at cycle t+LATENCY.
- WIDTH, 16, operand/result width; fp16 only.

Ports:
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-low reset
- prod_valid  in  1  product word valid
- prod_ready  out  1  reducer accepts product this cycle
- prod_data  in  WIDTH  fp16 product
- prod_last  in  1  final product of current row (every row has >=1 product)
- add_clk_en  out  1  adder clock enable
- add_dataa  out  WIDTH  adder operand A, registered
- add_datab  out  WIDTH  adder operand B, registered
- add_result  in  WIDTH  adder result
- add_overflow  in  1  adder overflow flag, aligned with add_result
- add_underflow  in  1  adder underflow flag, aligned with add_result
- row_valid  out  1  row sum valid
- row_ready  in  1  downstream accepts row sum
- row_sum  out  WIDTH  fp16 row sum
- row_overflow  out  1  sticky OR of adder overflow over the row
- row_underflow  out  1  sticky OR of adder underflow over the row

Behaviour:
- Reset values (asserted low, async):
  - add_clk_en=0, add_dataa=0, add_datab=0.
  - prod_ready=0, row_valid=0, row_sum=0, row_overflow=0, row_underflow=0.
  - Issue shift register, pending register and state all cleared.
- add_clk_en=1 whenever reset is deasserted; the adder never stalls.
- Validity is tracked by a LATENCY-deep issue-tag shift register. Tag out high means add_result is a live partial sum. Flags are sampled only when the tag is high.
- State machine:
  - ACCUM: prod_ready=1. Moves to DRAIN at the edge after a handshake with prod_last=1.
  - DRAIN: prod_ready=0. Moves to OUT when in-flight count==0, no tag at the output, and pending is valid (evaluated per cycle; row_valid rises the next cycle).
  - OUT: row_valid=1, row_sum=pending value. When row_valid and row_ready are both high: clear pending and flags, go to ACCUM.
- Operand selection, per cycle (in ACCUM or DRAIN). Sources are: accepted product I, adder output R (tag high), pending P. Priority:
  1. R and I: issue R+I; P unchanged.
  2. Else P with one of {R, I}: issue P+that source; P cleared.
  3. Else a single source: load it into P.
  4. No loss is possible: at most one leftover, and P is always free for it.
- In-flight counter is 0..LATENCY: +1 on issue, -1 on tag out, unchanged when both occur.
- Sticky flags: OR in add_overflow/add_underflow whenever the tag is high; cleared on row handshake.
- Latency:
  - 1-product row accepted at cycle t: row_valid at t+2.
  - 2-product row accepted at t and t+1: issue at t+1, result at t+1+LATENCY, row_valid at t+3+LATENCY.
- Summation order is scheduler-defined; only rounding may differ from a sequential sum.
- Output stall: row_valid stays high and row_sum/flags stay stable until row_ready; prod_ready stays 0 meanwhile.
- Reset mid-row: the in-flight tags are discarded, and adder results arriving after reset release are ignored.

Test Plan:
- Reset mid-row: assert reset during DRAIN with 3 adds in flight -> all outputs 0 immediately; after release, the first row 0x3C00,0x4000(last) -> row_sum 0x4200, uncorrupted by stale results.
- Single product 0x3C00 with last, row_ready=1 -> row_valid 2 cycles after accept, row_sum=0x3C00, flags 0.
- Back-to-back row 0x3C00,0x4000,0x4200,0x4400(last) -> row_sum=0x4900 (10.0), flags 0; prod_ready=0 from after last until handshake.
- Eight products of 0x3C00 with gapless prod_valid -> row_sum=0x4800 (8.0); in-flight never exceeds LATENCY; no product dropped.
- Row 0x7BFF,0x7BFF(last) with model adder asserting overflow -> row_sum=0x7C00, row_overflow=1; the next row 0x3C00(last) shows row_overflow=0.
- row_ready held 0 for 20 cycles in OUT -> row_valid, row_sum and flags stable, prod_ready=0; releasing row_ready gives exactly one handshake, then prod_ready=1 next cycle.
